pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter sequencer and phase controller for the 4-entry return-address stack block.
- Generates the two-phase ck2 signal: FETCH phase drives ck2=1, EXEC phase drives ck2=0.
- Gates the stack's kind input so the stack is only pushed or popped when it is safe.
- Selects the next PC from sequential, jump, call or return sources; halts on stack overflow, stack underflow or instruction-fetch timeout.

Parameters:
- AW, 12, address width of pc, one_addr, jmp_addr and stack_d.
- RESET_PC, 12'h000, pc value loaded on reset.
- DEPTH, 4, stack entry count; full when sp==DEPTH.
- TMO_CYC, 15, maximum FETCH cycles without imem_rdy before a timeout fault; counter width is 4 bits.

Ports:
- ck  in  1  system clock; all state changes on posedge.
- res  in  1  reset, active-low, synchronous.
- run  in  1  1 = fetch and execute continuously.
- imem_rdy  in  1  instruction memory has the word for pc on this cycle.
- kind  in  4  decoded instruction class, valid during EXEC.
- cond  in  1  branch condition flag, valid during EXEC.
- jmp_addr  in  AW  target address from the instruction, valid during EXEC.
- stack_d  in  AW  stack top-of-stack.
- sp  in  3  stack pointer.
- pc  out  AW  current program counter.
- fetch_req  out  1  instruction fetch request for pc.
- ck2  out  1  stack phase; 0 only during EXEC.
- one_addr  out  AW  return address pc+1, driven to the stack.
- stk_kind  out  4  gated kind driven to the stack.
- halted  out  1  sequencer is in HALT.
- fault  out  2  fault code: 00 none, 01 overflow, 10 underflow, 11 fetch timeout.

Behaviour:
- Reset: res==0 at posedge ck gives state=IDLE, pc=RESET_PC, ck2=1, fetch_req=0, halted=0, fault=00, timeout counter=0. Reset has priority in every state, including mid-FETCH and HALT.
- kind encodings: 0000 NOP, 0100 JMP, 0101 BR (taken when cond=1), 0110 JSB, 0111 RET, 1111 HLT. All other codes behave as NOP.
- IDLE: ck2=1, fetch_req=0. run=1 moves to FETCH on the next edge.
- FETCH:
  - ck2=1, fetch_req=1, timeout counter increments each cycle.
  - imem_rdy=1 at the edge moves to EXEC and clears the counter.
  - If the counter reaches TMO_CYC with imem_rdy=0: go to HALT with fault=11.
- EXEC (exactly one cycle):
  - ck2=0 for the whole cycle.
  - one_addr = pc+1, modulo 2^AW.
  - stk_kind = kind, except it is forced to 0000 on a fault. The stack pushes or pops on the edge that ends EXEC.
- Next pc at the end of EXEC:
  - JMP, and BR with cond=1: jmp_addr.
  - JSB: jmp_addr, taken only if sp<DEPTH.
  - RET: stack_d sampled before the pop, taken only if sp>0.
  - All others, including BR with cond=0: pc+1, wrapping 0xFFF to 0x000.
- Faults in EXEC:
  - JSB with sp==DEPTH: fault=01, pc unchanged, go to HALT.
  - RET with sp==0: fault=10, pc unchanged, go to HALT.
- HLT: pc unchanged, fault=00, go to HALT.
- After a normal EXEC: run=1 goes to FETCH; run=0 goes to IDLE. Deasserting run mid-FETCH still completes the current instruction.
- HALT: halted=1, ck2=1, fetch_req=0, stk_kind=0000. fault and pc are held. Only reset exits HALT.
- Outside EXEC, stk_kind=0000 and one_addr still reflects pc+1.
- Minimum 2 cycles per instruction.

Optional Feature:
- Macro: PCSEQ_SINGLE_STEP_EN.
- When defined:
  - An extra input port step (1 bit) is added.
  - In IDLE with run=0, a rising edge of step, registered, runs exactly one FETCH+EXEC and then returns to IDLE.
  - A step that arrives during a step is ignored.
  - run=1 takes priority over step.
- When undefined: there is no step port, and IDLE leaves only on run=1.

Test Plan:
- Reset then run=1 with imem_rdy=1 every cycle and kind=NOP → pc sequence 000,001,002. ck2 pattern 1,0,1,0. stk_kind=0000 throughout.
- JSB at pc=010 with jmp_addr=200 and sp=0 → in EXEC one_addr=011 and stk_kind=0110; next pc=200. A following RET with stack_d=011 → pc=011.
- Five nested JSBs → the fifth EXEC sees sp=4: stk_kind=0000, fault=01, halted=1, pc holds at the fifth JSB address. Reset → fault=00, pc=000.
- RET with sp=0 → fault=10, halted=1, stk_kind stays 0000. BR with cond=0 at pc=FFF → pc=000 (wrap).
- run=1 with imem_rdy held 0 → after 15 FETCH cycles fault=11 and halted=1. imem_rdy asserted on cycle 14 → normal EXEC, no fault.
- Reset asserted mid-FETCH → on that edge state=IDLE, fetch_req=0, pc=RESET_PC. With PCSEQ_SINGLE_STEP_EN defined, run=0 and one step pulse → exactly one pc increment.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: two-phase program-counter sequencer and kind gate for the 4-entry return stack.
// Define PCSEQ_SINGLE_STEP_EN to add the registered single-step input 'step'.
module pc_sequencer #(
  parameter int unsigned   AW       = 12,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int unsigned   DEPTH    = 4,
  parameter int unsigned   TMO_CYC  = 15
) (
  input  logic          ck,
  input  logic          res,
  input  logic          run,
`ifdef PCSEQ_SINGLE_STEP_EN
  input  logic          step,
`endif
  input  logic          imem_rdy,
  input  logic [3:0]    kind,
  input  logic          cond,
  input  logic [AW-1:0] jmp_addr,
  input  logic [AW-1:0] stack_d,
  input  logic [2:0]    sp,
  output logic [AW-1:0] pc,
  output logic          fetch_req,
  output logic          ck2,
  output logic [AW-1:0] one_addr,
  output logic [3:0]    stk_kind,
  output logic          halted,
  output logic [1:0]    fault
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  localparam logic [3:0] K_JMP    = 4'b0100;
  localparam logic [3:0] K_BR     = 4'b0101;
  localparam logic [3:0] K_JSB    = 4'b0110;
  localparam logic [3:0] K_RET    = 4'b0111;
  localparam logic [3:0] K_HLT    = 4'b1111;
  localparam logic [2:0] SP_FULL  = 3'(DEPTH);
  localparam logic [3:0] CNT_LAST = 4'(TMO_CYC - 1);

  state_t        state, state_nx;
  logic [AW-1:0] pc_nx, pc_inc;
  logic [3:0]    cnt, cnt_nx;
  logic [1:0]    fault_nx;
  logic          jsb_ovf, ret_unf, go;

`ifdef PCSEQ_SINGLE_STEP_EN
  logic step_q, step_qq;

  always_ff @(posedge ck) begin
    if (!res) begin
      step_q  <= 1'b0;
      step_qq <= 1'b0;
    end else begin
      step_q  <= step;
      step_qq <= step_q;
    end
  end

  // Step edges are only looked at in IDLE, so a step arriving mid-instruction is dropped.
  assign go = run | (step_q & ~step_qq);
`else
  assign go = run;
`endif

  assign pc_inc  = pc + AW'(1);
  assign jsb_ovf = (kind == K_JSB) && (sp >= SP_FULL);
  assign ret_unf = (kind == K_RET) && (sp == '0);

  always_ff @(posedge ck) begin
    if (!res) begin
      state <= IDLE;
      pc    <= RESET_PC;
      cnt   <= '0;
      fault <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      cnt   <= cnt_nx;
      fault <= fault_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    cnt_nx   = cnt;
    fault_nx = fault;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (go) state_nx = FETCH;
      end
      FETCH: begin
        if (imem_rdy) begin
          state_nx = EXEC;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 4'd1;
          if (cnt == CNT_LAST) begin
            state_nx = HALT;
            fault_nx = 2'b11;
          end
        end
      end
      EXEC: begin
        if (jsb_ovf) begin
          state_nx = HALT;
          fault_nx = 2'b01;
        end else if (ret_unf) begin
          state_nx = HALT;
          fault_nx = 2'b10;
        end else if (kind == K_HLT) begin
          state_nx = HALT;
        end else begin
          state_nx = run ? FETCH : IDLE;
          case (kind)
            K_JMP, K_JSB: pc_nx = jmp_addr;
            K_BR:         pc_nx = cond ? jmp_addr : pc_inc;
            K_RET:        pc_nx = stack_d;
            default:      pc_nx = pc_inc;
          endcase
        end
      end
      HALT: state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    fetch_req = (state == FETCH);
    ck2       = (state != EXEC);
    halted    = (state == HALT);
    one_addr  = pc_inc;
    stk_kind  = (state == EXEC && !(jsb_ovf || ret_unf)) ? kind : '0;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against an instruction-level model
// with a queue-based return stack standing in for the real stack block.
module tb_pc_sequencer;

  logic        ck = 1'b0;
  logic        res = 1'b1;
  logic        run = 1'b0;
  logic        imem_rdy = 1'b0;
  logic [3:0]  kind = '0;
  logic        cond = 1'b0;
  logic [11:0] jmp_addr = '0;
  logic [11:0] stack_d = '0;
  logic [2:0]  sp = '0;
`ifdef PCSEQ_SINGLE_STEP_EN
  logic        step = 1'b0;
`endif
  logic [11:0] pc, one_addr;
  logic        fetch_req, ck2, halted;
  logic [3:0]  stk_kind;
  logic [1:0]  fault;

  int total = 0;
  int bad = 0;

  logic [11:0] mpc, exp_one, nxt_pc;
  logic [3:0]  exp_sk;
  logic        mhalt, nxt_halt, push, pop;
  logic [1:0]  mfault, nxt_fault;
  logic [11:0] stk[$];

  pc_sequencer #(.AW(12), .RESET_PC(12'h000), .DEPTH(4), .TMO_CYC(15)) dut (
    .ck(ck), .res(res), .run(run),
`ifdef PCSEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .imem_rdy(imem_rdy), .kind(kind), .cond(cond), .jmp_addr(jmp_addr),
    .stack_d(stack_d), .sp(sp), .pc(pc), .fetch_req(fetch_req), .ck2(ck2),
    .one_addr(one_addr), .stk_kind(stk_kind), .halted(halted), .fault(fault)
  );

  always #5 ck = ~ck;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic drive_stack();
    sp      = 3'(stk.size());
    stack_d = (stk.size() != 0) ? stk[stk.size()-1] : 12'h000;
  endtask

  task automatic do_reset();
    res = 1'b0; run = 1'b0; imem_rdy = 1'b0; kind = '0; cond = 1'b0;
    tick();
    res = 1'b1;
    stk.delete();
    mpc = 12'h000; mhalt = 1'b0; mfault = 2'b00;
    drive_stack();
  endtask

  // Called during a FETCH cycle: predicts the instruction outcome, then advances into EXEC.
  task automatic issue(input logic [3:0] k, input logic c, input logic [11:0] ja);
    exp_one = mpc + 12'd1;
    exp_sk = k; nxt_pc = mpc + 12'd1; nxt_halt = 1'b0; nxt_fault = 2'b00;
    push = 1'b0; pop = 1'b0;
    case (k)
      4'h4: nxt_pc = ja;
      4'h5: if (c) nxt_pc = ja;
      4'h6: if (stk.size() >= 4) begin
              exp_sk = 4'h0; nxt_pc = mpc; nxt_halt = 1'b1; nxt_fault = 2'b01;
            end else begin
              nxt_pc = ja; push = 1'b1;
            end
      4'h7: if (stk.size() == 0) begin
              exp_sk = 4'h0; nxt_pc = mpc; nxt_halt = 1'b1; nxt_fault = 2'b10;
            end else begin
              nxt_pc = stk[stk.size()-1]; pop = 1'b1;
            end
      4'hF: begin nxt_pc = mpc; nxt_halt = 1'b1; end
      default: ;
    endcase
    imem_rdy = 1'b1; kind = k; cond = c; jmp_addr = ja;
    tick();
    imem_rdy = 1'b0;
  endtask

  // Edge that ends EXEC: the stack acts on it, then the model commits.
  task automatic retire();
    tick();
    if (push) stk.push_back(exp_one);
    if (pop) void'(stk.pop_back());
    mpc = nxt_pc; mhalt = nxt_halt; mfault = nxt_fault;
    drive_stack();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (pc !== 12'h000) begin bad++; $display("FAIL reset_pc got=%h want=000", pc); end
    total++; if (fetch_req !== 1'b0) begin bad++; $display("FAIL reset_fetch got=%b want=0", fetch_req); end
    total++; if (ck2 !== 1'b1) begin bad++; $display("FAIL reset_ck2 got=%b want=1", ck2); end
    total++; if (halted !== 1'b0 || fault !== 2'b00) begin bad++; $display("FAIL reset_halt got=%b/%b want=0/00", halted, fault); end
    total++; if (stk_kind !== 4'h0 || one_addr !== 12'h001) begin bad++; $display("FAIL reset_stk got=%h/%h want=0/001", stk_kind, one_addr); end
    tick(); tick();
    total++; if (fetch_req !== 1'b0) begin bad++; $display("FAIL idle_hold got=%b want=0", fetch_req); end
  endtask

  task automatic test_nop_sequence();
    do_reset();
    run = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      total++; if (pc !== 12'(i) || ck2 !== 1'b1 || fetch_req !== 1'b1) begin
        bad++; $display("FAIL nop_fetch got=%h/%b/%b want=%h/1/1", pc, ck2, fetch_req, 12'(i));
      end
      issue(4'h0, 1'b0, 12'h000);
      total++; if (ck2 !== 1'b0 || stk_kind !== 4'h0) begin
        bad++; $display("FAIL nop_exec got=%b/%h want=0/0", ck2, stk_kind);
      end
      retire();
    end
  endtask

  task automatic test_call_return();
    do_reset();
    run = 1'b1;
    tick();
    issue(4'h4, 1'b0, 12'h010);
    retire();
    total++; if (pc !== 12'h010) begin bad++; $display("FAIL jmp_pc got=%h want=010", pc); end
    issue(4'h6, 1'b0, 12'h200);
    total++; if (one_addr !== 12'h011 || stk_kind !== 4'h6 || ck2 !== 1'b0) begin
      bad++; $display("FAIL jsb_exec got=%h/%h/%b want=011/6/0", one_addr, stk_kind, ck2);
    end
    retire();
    total++; if (pc !== 12'h200) begin bad++; $display("FAIL jsb_pc got=%h want=200", pc); end
    issue(4'h7, 1'b0, 12'h3C3);
    total++; if (stk_kind !== 4'h7) begin bad++; $display("FAIL ret_exec got=%h want=7", stk_kind); end
    retire();
    total++; if (pc !== 12'h011) begin bad++; $display("FAIL ret_pc got=%h want=011", pc); end
  endtask

  task automatic test_overflow();
    do_reset();
    run = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      issue(4'h6, 1'b0, 12'((i + 1) * 256));
      retire();
    end
    total++; if (pc !== 12'h400) begin bad++; $display("FAIL nest_pc got=%h want=400", pc); end
    issue(4'h6, 1'b0, 12'h777);
    total++; if (stk_kind !== 4'h0 || ck2 !== 1'b0) begin bad++; $display("FAIL ovf_exec got=%h/%b want=0/0", stk_kind, ck2); end
    retire();
    total++; if (halted !== 1'b1 || fault !== 2'b01 || pc !== 12'h400) begin
      bad++; $display("FAIL ovf_halt got=%b/%b/%h want=1/01/400", halted, fault, pc);
    end
    tick(); tick(); tick();
    total++; if (halted !== 1'b1 || fault !== 2'b01 || pc !== 12'h400 || fetch_req !== 1'b0 || stk_kind !== 4'h0 || ck2 !== 1'b1) begin
      bad++; $display("FAIL halt_hold got=%b/%b/%h/%b/%h/%b want=1/01/400/0/0/1", halted, fault, pc, fetch_req, stk_kind, ck2);
    end
    do_reset();
    total++; if (fault !== 2'b00 || pc !== 12'h000 || halted !== 1'b0) begin
      bad++; $display("FAIL halt_reset got=%b/%h/%b want=00/000/0", fault, pc, halted);
    end
  endtask

  task automatic test_underflow_wrap();
    do_reset();
    run = 1'b1;
    tick();
    issue(4'h7, 1'b0, 12'h055);
    total++; if (stk_kind !== 4'h0) begin bad++; $display("FAIL unf_exec got=%h want=0", stk_kind); end
    retire();
    total++; if (halted !== 1'b1 || fault !== 2'b10 || pc !== 12'h000 || stk_kind !== 4'h0) begin
      bad++; $display("FAIL unf_halt got=%b/%b/%h/%h want=1/10/000/0", halted, fault, pc, stk_kind);
    end
    do_reset();
    run = 1'b1;
    tick();
    issue(4'h4, 1'b0, 12'hFFF);
    retire();
    issue(4'h5, 1'b0, 12'h123);
    total++; if (one_addr !== 12'h000) begin bad++; $display("FAIL wrap_one got=%h want=000", one_addr); end
    retire();
    total++; if (pc !== 12'h000) begin bad++; $display("FAIL wrap_pc got=%h want=000", pc); end
  endtask

  task automatic test_timeout();
    do_reset();
    run = 1'b1;
    tick();
    for (int i = 0; i < 14; i++) tick();
    total++; if (fetch_req !== 1'b1 || halted !== 1'b0) begin bad++; $display("FAIL tmo_cyc15 got=%b/%b want=1/0", fetch_req, halted); end
    tick();
    total++; if (halted !== 1'b1 || fault !== 2'b11 || fetch_req !== 1'b0 || pc !== 12'h000) begin
      bad++; $display("FAIL tmo_halt got=%b/%b/%b/%h want=1/11/0/000", halted, fault, fetch_req, pc);
    end
    do_reset();
    run = 1'b1;
    tick();
    for (int i = 0; i < 13; i++) tick();
    issue(4'h0, 1'b0, 12'h000);
    total++; if (ck2 !== 1'b0 || halted !== 1'b0 || fault !== 2'b00) begin
      bad++; $display("FAIL rdy14_exec got=%b/%b/%b want=0/0/00", ck2, halted, fault);
    end
    retire();
    total++; if (pc !== 12'h001 || fetch_req !== 1'b1) begin bad++; $display("FAIL rdy14_pc got=%h/%b want=001/1", pc, fetch_req); end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    run = 1'b1;
    tick();
    issue(4'h4, 1'b0, 12'h0AB);
    retire();
    tick();
    total++; if (pc !== 12'h0AB || fetch_req !== 1'b1) begin bad++; $display("FAIL midf_pre got=%h/%b want=0ab/1", pc, fetch_req); end
    res = 1'b0;
    tick();
    total++; if (fetch_req !== 1'b0 || pc !== 12'h000 || ck2 !== 1'b1 || halted !== 1'b0) begin
      bad++; $display("FAIL midf_reset got=%b/%h/%b/%b want=0/000/1/0", fetch_req, pc, ck2, halted);
    end
    res = 1'b1; run = 1'b0;
    tick(); tick();
    total++; if (fetch_req !== 1'b0 || pc !== 12'h000) begin bad++; $display("FAIL midf_idle got=%b/%h want=0/000", fetch_req, pc); end
  endtask

  task automatic test_single_step();
`ifdef PCSEQ_SINGLE_STEP_EN
    int execs;
    do_reset();
    imem_rdy = 1'b1; step = 1'b0;
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    execs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ck2 === 1'b0) execs++;
    end
    imem_rdy = 1'b0;
    total++; if (pc !== 12'h001 || execs != 1 || fetch_req !== 1'b0) begin
      bad++; $display("FAIL step_once got=%h/%0d/%b want=001/1/0", pc, execs, fetch_req);
    end
`endif
  endtask

  task automatic test_random();
    int d, r;
    logic [3:0] k;
    logic rn;
    do_reset();
    run = 1'b1;
    tick();
    for (int n = 0; n < 80; n++) begin
      d = $urandom_range(0, 3);
      for (int i = 0; i < d; i++) begin
        run = 1'($urandom);
        total++; if (fetch_req !== 1'b1 || stk_kind !== 4'h0 || pc !== mpc) begin
          bad++; $display("FAIL rnd_fetch got=%b/%h/%h want=1/0/%h", fetch_req, stk_kind, pc, mpc);
        end
        tick();
      end
      r = $urandom_range(0, 19);
      case (r)
        0, 1, 2:    k = 4'h0;
        3, 4, 5:    k = 4'h4;
        6, 7, 8:    k = 4'h5;
        9, 10, 11:  k = 4'h6;
        12, 13, 14: k = 4'h7;
        19:         k = 4'hF;
        default:    k = 4'($urandom_range(8, 14));
      endcase
      issue(k, 1'($urandom), 12'($urandom));
      total++; if (ck2 !== 1'b0 || one_addr !== exp_one || stk_kind !== exp_sk || pc !== mpc) begin
        bad++; $display("FAIL rnd_exec k=%h got=%b/%h/%h/%h want=0/%h/%h/%h", k, ck2, one_addr, stk_kind, pc, exp_one, exp_sk, mpc);
      end
      rn = ($urandom_range(0, 3) != 0);
      run = rn;
      retire();
      total++; if (pc !== mpc || halted !== mhalt || fault !== mfault) begin
        bad++; $display("FAIL rnd_next k=%h got=%h/%b/%b want=%h/%b/%b", k, pc, halted, fault, mpc, mhalt, mfault);
      end
      if (mhalt) begin
        do_reset();
        run = 1'b1;
        tick();
      end else if (!rn) begin
        total++; if (fetch_req !== 1'b0 || ck2 !== 1'b1) begin
          bad++; $display("FAIL rnd_idle got=%b/%b want=0/1", fetch_req, ck2);
        end
        run = 1'b1;
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_nop_sequence();
    test_call_return();
    test_overflow();
    test_underflow_wrap();
    test_timeout();
    test_reset_mid_fetch();
    test_single_step();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
